// File: rtl/count8b_down_if.sv
// count8b_down_if
//   Load/start-stop bus shared by count8b_down and its up-counter sibling.
//   The controller (master) drives the load strobe, load value and run
//   level. The counter (slave) returns the count, the terminal-count pulse,
//   the zero flag, busy and its FSM state for observation.
//
//   Handshake: this bus has no valid/ready pair. l is a single-cycle
//   command strobe that is sampled on every rising clk edge and is always
//   accepted. s_s is a level, not a strobe. All slave outputs are registered
//   and change only on rising clk edges.
//
//   Signals:
//     l      master->slave  load strobe; d is captured into count and reload
//     s_s    master->slave  start/stop level; 1 = count, 0 = hold
//     d      master->slave  load value, WIDTH bits
//     c      slave->master  current count
//     tc     slave->master  one-cycle terminal-count pulse
//     zero   slave->master  c == 0
//     busy   slave->master  FSM is in RUN
//     state  slave->master  FSM state (debug/observation)
interface count8b_down_if #(
    parameter int WIDTH = 8
);
    logic             l;
    logic             s_s;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] c;
    logic             tc;
    logic             zero;
    logic             busy;
    logic [1:0]       state;

    modport master (
        output l, s_s, d,
        input  c, tc, zero, busy, state
    );

    modport slave (
        input  l, s_s, d,
        output c, tc, zero, busy, state
    );
endinterface

// File: rtl/count8b_down.sv
// count8b_down
//   Loadable down-counter / interval timer. A load captures d into the
//   count and into a reload register. While s_s is high the count steps
//   down to zero and a one-cycle tc pulse marks the cycle where it first
//   reads zero. With AUTO_RELOAD=1 the count is refilled from the reload
//   register on the next edge, which gives a tick every rld+1 cycles.
//
//   Ports:
//     clk    rising-edge clock
//     clr_n  synchronous active-low clear
//     bus    count8b_down_if.slave (l, s_s, d in; c, tc, zero, busy, state out)
//
//   Update priority on each edge: clear > load > count > hold.
module count8b_down #(
    parameter int WIDTH       = 8,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic                 clk,
    input  logic                 clr_n,
    count8b_down_if.slave        bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] ZERO_V = '0;
    localparam logic [WIDTH-1:0] ONE_V  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] c_q,     c_d;
    logic [WIDTH-1:0] rld_q,   rld_d;
    logic             tc_q,    tc_d;
    logic             zero_q,  zero_d;
    logic             busy_q,  busy_d;

    // One decrement step, shared by HOLD->RUN and RUN. Reaching zero moves
    // to DONE and fires tc; the c != 0 gate keeps the count from wrapping.
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        rld_d   = rld_q;
        tc_d    = 1'b0;

        if (bus.l) begin
            // A load never decrements, even with s_s high.
            c_d   = bus.d;
            rld_d = bus.d;
            if (bus.d == ZERO_V) begin
                state_d = ST_DONE;
            end else if (bus.s_s) begin
                state_d = ST_RUN;
            end else begin
                state_d = ST_HOLD;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_HOLD, ST_RUN: begin
                    if (!bus.s_s) begin
                        state_d = ST_HOLD;
                    end else if (c_q != ZERO_V) begin
                        c_d = c_q - ONE_V;
                        if (c_q == ONE_V) begin
                            tc_d    = 1'b1;
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_DONE: begin
                    // One-shot parks here; auto-reload refills when running
                    // and the reload value is non-zero.
                    if (AUTO_RELOAD && bus.s_s && (rld_q != ZERO_V)) begin
                        c_d     = rld_q;
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    c_d     = ZERO_V;
                end
            endcase
        end

        zero_d = (c_d == ZERO_V);
        busy_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q <= ST_IDLE;
            c_q     <= ZERO_V;
            rld_q   <= ZERO_V;
            tc_q    <= 1'b0;
            zero_q  <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            rld_q   <= rld_d;
            tc_q    <= tc_d;
            zero_q  <= zero_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.c     = c_q;
    assign bus.tc    = tc_q;
    assign bus.zero  = zero_q;
    assign bus.busy  = busy_q;
    assign bus.state = state_q;

endmodule

// File: tb/tb_count8b_down.sv
// tb_count8b_down
//   Directed bench for count8b_down. u_os is the one-shot build
//   (AUTO_RELOAD=0) and u_ar the auto-reload build; both share clk/clr_n.
//   Inputs change 1 time unit after a rising edge; outputs are sampled there.
module tb_count8b_down;

    logic clk;
    logic clr_n;

    count8b_down_if #(.WIDTH(8)) bus_os ();
    count8b_down_if #(.WIDTH(8)) bus_ar ();

    count8b_down #(.WIDTH(8), .AUTO_RELOAD(1'b0)) u_os (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus_os.slave)
    );

    count8b_down #(.WIDTH(8), .AUTO_RELOAD(1'b1)) u_ar (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus_ar.slave)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // driver tasks
    task automatic drive_os(input logic l, input logic s_s, input logic [7:0] d);
        bus_os.l   = l;
        bus_os.s_s = s_s;
        bus_os.d   = d;
    endtask

    task automatic drive_ar(input logic l, input logic s_s, input logic [7:0] d);
        bus_ar.l   = l;
        bus_ar.s_s = s_s;
        bus_ar.d   = d;
    endtask

    task automatic check_os(input string tag, input logic [7:0] c, input logic tc,
                            input logic busy);
        check({tag, ".c"},    {24'd0, bus_os.c},    {24'd0, c});
        check({tag, ".tc"},   {31'd0, bus_os.tc},   {31'd0, tc});
        check({tag, ".zero"}, {31'd0, bus_os.zero}, {31'd0, (c == 8'd0)});
        check({tag, ".busy"}, {31'd0, bus_os.busy}, {31'd0, busy});
    endtask

    task automatic check_ar(input string tag, input logic [7:0] c, input logic tc,
                            input logic busy);
        check({tag, ".c"},    {24'd0, bus_ar.c},    {24'd0, c});
        check({tag, ".tc"},   {31'd0, bus_ar.tc},   {31'd0, tc});
        check({tag, ".zero"}, {31'd0, bus_ar.zero}, {31'd0, (c == 8'd0)});
        check({tag, ".busy"}, {31'd0, bus_ar.busy}, {31'd0, busy});
    endtask

    initial begin
        int pulses;
        int cycles;
        n_cmp = 0;
        n_err = 0;

        // 1. reset with s_s high
        clr_n = 1'b0;
        drive_os(1'b0, 1'b1, 8'h00);
        drive_ar(1'b0, 1'b1, 8'h00);
        tick();
        tick();
        check_os("rst_os", 8'h00, 1'b0, 1'b0);
        check_ar("rst_ar", 8'h00, 1'b0, 1'b0);
        check("rst_state", {30'd0, bus_os.state}, 32'd0);
        clr_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_os("idle", 8'h00, 1'b0, 1'b0);
        end

        // 4. auto-reload: load 3, run 20 cycles -> tc every 4 cycles
        drive_ar(1'b1, 1'b1, 8'h03);
        tick();
        check_ar("ar_load", 8'h03, 1'b0, 1'b1);
        drive_ar(1'b0, 1'b1, 8'h00);
        pulses = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            check_ar("ar_run", 8'(3 - (i % 4)), ((i % 4) == 3), ((i % 4) != 3));
            if (bus_ar.tc) pulses++;
        end
        check("ar_pulses", pulses, 32'd5);

        // auto-reload with s_s low waits in DONE, resumes when raised
        drive_ar(1'b1, 1'b1, 8'h01);
        tick();
        check_ar("ar1_load", 8'h01, 1'b0, 1'b1);
        drive_ar(1'b0, 1'b1, 8'h00);
        tick();
        check_ar("ar1_tc", 8'h00, 1'b1, 1'b0);
        drive_ar(1'b0, 1'b0, 8'h00);
        tick();
        check_ar("ar1_wait0", 8'h00, 1'b0, 1'b0);
        tick();
        check_ar("ar1_wait1", 8'h00, 1'b0, 1'b0);
        drive_ar(1'b0, 1'b1, 8'h00);
        tick();
        check_ar("ar1_reload", 8'h01, 1'b0, 1'b1);

        // auto-reload with rld == 0 stays in DONE, no tc
        drive_ar(1'b1, 1'b1, 8'h00);
        tick();
        check_ar("ar0_load", 8'h00, 1'b0, 1'b0);
        drive_ar(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_ar("ar0_stay", 8'h00, 1'b0, 1'b0);
        end
        drive_ar(1'b0, 1'b0, 8'h00);

        // 2. one-shot load 5
        drive_os(1'b1, 1'b1, 8'h05);
        tick();
        check_os("os_load", 8'h05, 1'b0, 1'b1);
        drive_os(1'b0, 1'b1, 8'h00);
        for (int i = 4; i >= 0; i--) begin
            tick();
            check_os("os_run", 8'(i), (i == 0), (i != 0));
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            check_os("os_done", 8'h00, 1'b0, 1'b0);
        end
        check("os_state", {30'd0, bus_os.state}, 32'd3);

        // 3. pause
        drive_os(1'b1, 1'b1, 8'h10);
        tick();
        check_os("p_load", 8'h10, 1'b0, 1'b1);
        drive_os(1'b0, 1'b1, 8'h00);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_os("p_run", 8'(16 - i), 1'b0, 1'b1);
        end
        drive_os(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_os("p_hold", 8'h0C, 1'b0, 1'b0);
        end
        drive_os(1'b0, 1'b1, 8'h00);
        tick();
        check_os("p_resume", 8'h0B, 1'b0, 1'b1);

        // 5. load mid-run at 8
        for (int i = 0; i < 3; i++) tick();
        check_os("m_at8", 8'h08, 1'b0, 1'b1);
        drive_os(1'b1, 1'b1, 8'h20);
        tick();
        check_os("m_load", 8'h20, 1'b0, 1'b1);
        drive_os(1'b0, 1'b1, 8'h00);
        tick();
        check_os("m_dec", 8'h1F, 1'b0, 1'b1);

        // l held several cycles keeps c at d
        drive_os(1'b1, 1'b1, 8'h07);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_os("l_held", 8'h07, 1'b0, 1'b1);
        end

        // 6. load zero -> DONE, no tc
        drive_os(1'b1, 1'b1, 8'h00);
        tick();
        check_os("z_load", 8'h00, 1'b0, 1'b0);
        check("z_state", {30'd0, bus_os.state}, 32'd3);
        drive_os(1'b0, 1'b1, 8'h00);
        tick();
        check_os("z_stay", 8'h00, 1'b0, 1'b0);

        // all-ones load runs 255 cycles to tc
        drive_os(1'b1, 1'b1, 8'hFF);
        tick();
        check_os("ff_load", 8'hFF, 1'b0, 1'b1);
        drive_os(1'b0, 1'b1, 8'h00);
        cycles = 0;
        while (!bus_os.tc && cycles < 300) begin
            tick();
            cycles++;
        end
        check("ff_len", cycles, 32'd255);
        check_os("ff_end", 8'h00, 1'b1, 1'b0);

        // load FF, run, reset mid-count
        drive_os(1'b1, 1'b1, 8'hFF);
        tick();
        drive_os(1'b0, 1'b1, 8'h00);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check_os("r_run", 8'(255 - i), 1'b0, 1'b1);
        end
        clr_n = 1'b0;
        tick();
        check_os("r_clr", 8'h00, 1'b0, 1'b0);
        clr_n = 1'b1;
        tick();
        check_os("r_after", 8'h00, 1'b0, 1'b0);
        check("r_state", {30'd0, bus_os.state}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
